// File: rtl/fifo_pkg.sv
// Shared constants and helpers for FIFO read-side and stream buffer blocks.
package fifo_pkg;

  // FIFO read latency options: data with the pop, or one cycle after it.
  localparam int FIFO_RD_LAT_COMB = 0;
  localparam int FIFO_RD_LAT_REG  = 1;

  // Output stream buffer geometry.
  localparam int STREAM_BUF_DEPTH = 2;
  localparam int STREAM_OCC_WIDTH = $clog2(STREAM_BUF_DEPTH + 1);

  typedef logic [STREAM_OCC_WIDTH-1:0] stream_occ_t;

  localparam logic [STREAM_OCC_WIDTH:0] STREAM_BUF_DEPTH_W = STREAM_BUF_DEPTH[STREAM_OCC_WIDTH:0];

  // True when words already held or promised, less the one leaving this
  // cycle, still leave room for one more. fire implies occ >= 1, so the
  // subtraction cannot underflow.
  function automatic logic slot_free(input stream_occ_t occ, input logic inflight,
                                     input logic fire);
    logic [STREAM_OCC_WIDTH:0] sum;
    sum = {1'b0, occ}
        + {{STREAM_OCC_WIDTH{1'b0}}, inflight}
        - {{STREAM_OCC_WIDTH{1'b0}}, fire};
    return sum < STREAM_BUF_DEPTH_W;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream output, bundled for the reader.
interface fifo_stream_reader_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   fifo_empty;
  logic                   fifo_read_en;
  logic [WORD_LENGTH-1:0] data;
  logic                   valid;
  logic                   ready;

  // Reader side: pops the FIFO and drives the stream.
  modport master (
    input  fifo_data, fifo_empty, ready,
    output fifo_read_en, data, valid
  );

  // Environment side: the FIFO and the stream consumer.
  modport slave (
    output fifo_data, fifo_empty, ready,
    input  fifo_read_en, data, valid
  );
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry in-order valid/ready buffer. The head is always r_head, so the
// stream output is purely registered and holds while not accepted.
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wr_en,
  input  logic [WORD_LENGTH-1:0] i_wr_data,
  input  logic                   i_ready,
  output logic [WORD_LENGTH-1:0] o_data,
  output logic                   o_valid,
  output stream_occ_t            o_occ,
  output logic                   o_fire
);

  localparam stream_occ_t OCC_ONE = stream_occ_t'(1);

  logic [WORD_LENGTH-1:0] r_head;
  logic [WORD_LENGTH-1:0] r_tail;
  stream_occ_t            r_occ;
  logic                   w_fire;

  assign o_valid = (r_occ != '0);
  assign w_fire  = o_valid & i_ready;
  assign o_fire  = w_fire;
  assign o_data  = r_head;
  assign o_occ   = r_occ;

  // Shift/append the two entries; a write alongside a fire keeps occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({i_wr_en, w_fire})
        2'b10: begin
          if (r_occ == '0) r_head <= i_wr_data;
          else             r_tail <= i_wr_data;
          r_occ <= r_occ + OCC_ONE;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - OCC_ONE;
        end
        2'b11: begin
          if (r_occ == OCC_ONE) begin
            r_head <= i_wr_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops an internal FIFO and presents the words on a valid/ready stream,
// absorbing a 0- or 1-cycle FIFO read latency without bubbles.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  fifo_stream_reader_if.master   io_bus,
  output logic [COUNT_WIDTH-1:0] o_word_count
);

  logic                   r_inflight;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_pop;
  logic                   w_fire;
  logic                   w_wr_en;
  stream_occ_t            w_occ;

  // Pop only when the word cannot overflow the buffer, counting any word
  // still in flight and the one leaving this cycle; held off during reset.
  assign w_pop = i_reset_n & i_enable & ~io_bus.fifo_empty
               & slot_free(w_occ, r_inflight, w_fire);

  assign io_bus.fifo_read_en = w_pop;
  assign o_word_count        = r_count;

  // With combinational read data the word lands at the pop edge; otherwise
  // it lands one edge later, tracked by r_inflight.
  assign w_wr_en = (READ_LATENCY == FIFO_RD_LAT_COMB) ? w_pop : r_inflight;

  // In-flight flag: a registered copy of the pop for the registered FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_inflight <= 1'b0;
    else            r_inflight <= (READ_LATENCY == FIFO_RD_LAT_REG) ? w_pop : 1'b0;
  end

  // Delivered-word counter, wraps naturally at 2^COUNT_WIDTH.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_count <= '0;
    else            r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, w_fire};
  end

  stream_skid_buffer #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_buf (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (w_wr_en),
    .i_wr_data (io_bus.fifo_data),
    .i_ready   (io_bus.ready),
    .o_data    (io_bus.data),
    .o_valid   (io_bus.valid),
    .o_occ     (w_occ),
    .o_fire    (w_fire)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: two readers (comb and registered FIFO latency) share one stimulus
// and one FIFO word store, each with its own read pointer and stream model.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int MEMW = 4096;
  localparam int LOGW = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, ready;
  logic [7:0] mem [MEMW];
  int fifo_wr;
  int f_rd [2];
  logic [7:0] f_q1 [2];
  int cyc = 0;

  fifo_stream_reader_if #(.WORD_LENGTH(8)) bus0 ();
  fifo_stream_reader_if #(.WORD_LENGTH(8)) bus1 ();
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  fifo_stream_reader #(.WORD_LENGTH(8), .READ_LATENCY(0), .COUNT_WIDTH(4)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .io_bus(bus0), .o_word_count(cnt0));
  fifo_stream_reader #(.WORD_LENGTH(8), .READ_LATENCY(1), .COUNT_WIDTH(16)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .io_bus(bus1), .o_word_count(cnt1));

  // FIFO environment: lane 0 data is combinational, lane 1 registered.
  assign bus0.fifo_data  = mem[f_rd[0] % MEMW];
  assign bus1.fifo_data  = f_q1[1];
  assign bus0.fifo_empty = (f_rd[0] >= fifo_wr);
  assign bus1.fifo_empty = (f_rd[1] >= fifo_wr);
  assign bus0.ready = ready;
  assign bus1.ready = ready;

  logic       d_valid [2];
  logic       d_ren   [2];
  logic [7:0] d_data  [2];
  int         d_cnt   [2];
  always_comb begin
    d_valid[0] = bus0.valid;        d_valid[1] = bus1.valid;
    d_ren[0]   = bus0.fifo_read_en; d_ren[1]   = bus1.fifo_read_en;
    d_data[0]  = bus0.data;         d_data[1]  = bus1.data;
    d_cnt[0]   = int'(cnt0);        d_cnt[1]   = int'(cnt1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        f_rd[l] <= 0;
        f_q1[l] <= 8'h00;
      end else if (d_ren[l]) begin
        f_rd[l] <= f_rd[l] + 1;
        f_q1[l] <= mem[f_rd[l] % MEMW];
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input int lane, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", name, lane, act, exp);
    end
  endtask

  function automatic int cmask(input int l);
    return (l == 0) ? 32'h000F : 32'hFFFF;
  endfunction

  function automatic int get_occ(input int l);
    return (l == 0) ? int'(u_dut0.w_occ) : int'(u_dut1.w_occ);
  endfunction

  // Behavioural stream model: a word list per lane plus pending pops.
  logic [7:0] m_buf [2][2];
  int         m_occ [2];
  bit         m_infl [2];
  logic [7:0] m_pend [2];
  int         m_rd [2];
  int         m_cnt [2];
  bit e_valid, e_fire, e_ren;

  logic [7:0] log_data [2][LOGW];
  int         log_cyc  [2][LOGW];
  int         log_n [2] = '{0, 0};
  int         first_ren [2] = '{-1, -1};
  int         first_valid [2] = '{-1, -1};

  task automatic put(input int l, input logic [7:0] w);
    check("buf_overflow", l, int'(m_occ[l] < 2), 1);
    if (m_occ[l] < 2) begin
      m_buf[l][m_occ[l]] = w;
      m_occ[l]++;
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      e_valid = (m_occ[l] != 0);
      e_fire  = e_valid && ready;
      e_ren   = rst_n && enable && (m_rd[l] < fifo_wr)
             && (m_occ[l] + (m_infl[l] ? 1 : 0) - (e_fire ? 1 : 0) < 2);
      if (!rst_n) begin
        check("ren_in_reset", l, int'(d_ren[l]), 0);
        m_occ[l] = 0; m_infl[l] = 1'b0; m_rd[l] = 0; m_cnt[l] = 0;
      end else begin
        check("valid", l, int'(d_valid[l]), int'(e_valid));
        check("read_en", l, int'(d_ren[l]), int'(e_ren));
        check("word_count", l, d_cnt[l], m_cnt[l] & cmask(l));
        if (e_valid) check("data", l, int'(d_data[l]), int'(m_buf[l][0]));
        check("occ_bound", l, int'(get_occ(l) <= 2), 1);
        if (d_valid[l] && ready) begin
          log_data[l][log_n[l] % LOGW] = d_data[l];
          log_cyc[l][log_n[l] % LOGW]  = cyc;
          log_n[l]++;
        end
        if (first_ren[l] < 0 && d_ren[l])     first_ren[l] = cyc;
        if (first_valid[l] < 0 && d_valid[l]) first_valid[l] = cyc;
        if (e_fire) begin
          m_buf[l][0] = m_buf[l][1];
          m_occ[l]--;
          m_cnt[l]++;
        end
        if (l == 1) begin
          if (m_infl[l]) put(l, m_pend[l]);
          m_infl[l] = e_ren;
          if (e_ren) begin
            m_pend[l] = mem[m_rd[l] % MEMW];
            m_rd[l]++;
          end
        end else if (e_ren) begin
          put(l, mem[m_rd[l] % MEMW]);
          m_rd[l]++;
        end
      end
    end
  end

  // Stimulus helpers.
  int base [2];
  logic [7:0] exp_w [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[fifo_wr % MEMW] = b;
    fifo_wr++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; fifo_wr = 0; enable = 1'b0; ready = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_marks();
    for (int l = 0; l < 2; l++) begin
      base[l] = log_n[l];
      first_ren[l] = -1;
      first_valid[l] = -1;
    end
  endtask

  task automatic check_zero(input string name);
    for (int l = 0; l < 2; l++) begin
      check({name, "_valid"}, l, int'(d_valid[l]), 0);
      check({name, "_data"},  l, int'(d_data[l]), 0);
      check({name, "_count"}, l, d_cnt[l], 0);
      check({name, "_ren"},   l, int'(d_ren[l]), 0);
    end
  endtask

  task automatic check_log(input string name, input int n);
    for (int l = 0; l < 2; l++) begin
      check({name, "_words"}, l, log_n[l] - base[l], n);
      for (int k = 0; k < n; k++)
        check(name, l, int'(log_data[l][(base[l] + k) % LOGW]), int'(exp_w[k]));
    end
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; fifo_wr = 0;

    // 1: preloaded 11/22/33, first-word latency and ordering.
    do_reset(2);
    check_zero("reset");
    set_marks();
    push(8'h11); push(8'h22); push(8'h33);
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
    enable = 1'b1; ready = 1'b1;
    repeat (10) tick();
    for (int l = 0; l < 2; l++) begin
      check("t1_latency", l, first_valid[l] - first_ren[l], (l == 0) ? 1 : 2);
      check("t1_consecutive", l, log_cyc[l][(base[l] + 2) % LOGW] - log_cyc[l][base[l] % LOGW], 2);
      check("t1_count", l, d_cnt[l], 3);
      check("t1_idle_ren", l, int'(d_ren[l]), 0);
    end
    check_log("t1_order", 3);

    // 2: 10-word burst, fire on consecutive cycles.
    enable = 1'b0; ready = 1'b1;
    set_marks();
    for (int k = 0; k < 10; k++) begin
      push(8'(8'h60 + k));
      exp_w[k] = 8'(8'h60 + k);
    end
    tick();
    enable = 1'b1;
    repeat (16) tick();
    check_log("t2_burst", 10);
    for (int l = 0; l < 2; l++)
      check("t2_back_to_back", l, log_cyc[l][(base[l] + 9) % LOGW] - log_cyc[l][base[l] % LOGW], 9);

    // 3: backpressure holds 0xA5, buffer fills, pops stop, then drains in order.
    ready = 1'b0; enable = 1'b1;
    set_marks();
    push(8'hA5); push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    exp_w[0] = 8'hA5; exp_w[1] = 8'hB1; exp_w[2] = 8'hB2; exp_w[3] = 8'hB3; exp_w[4] = 8'hB4;
    repeat (8) tick();
    for (int l = 0; l < 2; l++) begin
      check("t3_hold_valid", l, int'(d_valid[l]), 1);
      check("t3_hold_data", l, int'(d_data[l]), 32'hA5);
      check("t3_occ_full", l, get_occ(l), 2);
      check("t3_ren_low", l, int'(d_ren[l]), 0);
    end
    ready = 1'b1;
    repeat (10) tick();
    check_log("t3_order", 5);

    // 4: disable right after a pop; in-flight word still delivered.
    ready = 1'b1; enable = 1'b1;
    set_marks();
    push(8'h40);
    tick();
    enable = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    repeat (8) tick();
    for (int l = 0; l < 2; l++) begin
      check("t4_ren_low", l, int'(d_ren[l]), 0);
      check("t4_one_word", l, log_n[l] - base[l], 1);
      check("t4_first", l, int'(log_data[l][base[l] % LOGW]), 32'h40);
    end
    enable = 1'b1;
    for (int k = 0; k < 5; k++) exp_w[k] = 8'(8'h40 + k);
    repeat (10) tick();
    check_log("t4_order", 5);

    // 5: counter wrap after 17 accepted words.
    do_reset(2);
    enable = 1'b1; ready = 1'b1;
    for (int k = 0; k < 17; k++) push(8'(k));
    repeat (30) tick();
    check("t5_wrap", 0, d_cnt[0], 1);
    check("t5_count", 1, d_cnt[1], 17);

    // 6: one-cycle reset with words buffered and in flight.
    ready = 1'b0; enable = 1'b1;
    for (int k = 0; k < 5; k++) push(8'(8'hC0 + k));
    tick(); tick();
    do_reset(1);
    check_zero("t6_reset");
    set_marks();
    push(8'h5A);
    exp_w[0] = 8'h5A;
    enable = 1'b1; ready = 1'b1;
    repeat (6) tick();
    check_log("t6_fresh", 1);
    for (int l = 0; l < 2; l++) check("t6_count", l, d_cnt[l], 1);

    // Random traffic against the model, then drain.
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && fifo_wr < 3000) push(8'($urandom));
      tick();
    end
    enable = 1'b1; ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick();
      done = (m_occ[0] == 0) && (m_occ[1] == 0) && !m_infl[1]
          && (m_rd[0] == fifo_wr) && (m_rd[1] == fifo_wr);
    end
    check("drain_done", 0, int'(done), 1);
    repeat (2) tick();
    check("rand_total", 0, d_cnt[0], fifo_wr % 16);
    check("rand_total", 1, d_cnt[1], fifo_wr % 65536);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
